decode_stage: RTL and testbench

Registered, handshaked instruction-decode stage for the RV32I/RV64I datapath. It accepts a fetched instruction and PC over a valid/ready interface and splits the instruction into register indices, opcode and funct fields. It also classifies the instruction format and generates a fully sign-extended XLEN-wide immediate for every base format. A 2-entry skid buffer gives full throughput while keeping `in_ready` registered. The block sits between fetch and register-read/ALU control.

---
 rtl/decode_stage_if.sv | 43 ++++
 rtl/decode_stage.sv | 163 ++++++++++++++++
 tb/tb_decode_stage.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// decode_stage_if: handshake and decoded-field bundle for decode_stage.
//   Upstream side : flush_i, in_valid_i, in_ready_o, instr_i, pc_i
//   Downstream    : out_valid_o, out_ready_i, rs1_o, rs2_o, rd_o, opcode_o,
//                   funct3_o, funct7_o, alu_sel_o, fmt_o, imm_o, pc_o, illegal_o
//   Modport slave is the decode stage's view; master is the environment's view.
// Handshake: a transfer happens on a rising edge where valid && ready.
//   in_valid_i may be asserted at any time. A valid output entry
//   (out_valid_o=1) keeps every field stable until out_ready_i takes it.
interface decode_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     instr_i;
  logic [PC_W-1:0] pc_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [4:0]      rs1_o;
  logic [4:0]      rs2_o;
  logic [4:0]      rd_o;
  logic [6:0]      opcode_o;
  logic [2:0]      funct3_o;
  logic [6:0]      funct7_o;
  logic [3:0]      alu_sel_o;
  logic [2:0]      fmt_o;
  logic [XLEN-1:0] imm_o;
  logic [PC_W-1:0] pc_o;
  logic            illegal_o;

  modport slave (
    input  flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
    output in_ready_o, out_valid_o, rs1_o, rs2_o, rd_o, opcode_o, funct3_o,
           funct7_o, alu_sel_o, fmt_o, imm_o, pc_o, illegal_o
  );

  modport master (
    output flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, rs1_o, rs2_o, rd_o, opcode_o, funct3_o,
           funct7_o, alu_sel_o, fmt_o, imm_o, pc_o, illegal_o
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I instruction decode with a 2-entry
// skid buffer (main/output register + skid register).
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : decode_stage_if.slave (input handshake, flush, decoded outputs)
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN enables illegal-instruction
// detection (illegal_o, immediate forced to 0 on illegal entries). Without it
// illegal_o is tied to 0.
// fmt encoding: 0=R 1=I 2=S 3=B 4=U 5=J 7=invalid.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input logic            clk,
  input logic            rst,
  decode_stage_if.slave  bus
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_BAD = 3'd7;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [3:0]      alu_sel;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic [PC_W-1:0] pc;
    logic            illegal;
  } entry_t;

  entry_t dec;
  logic [31:0] imm32;
  logic [31:0] ins;

  // Combinational decode of the incoming word.
  always_comb begin
    ins         = bus.instr_i;
    dec         = '0;
    imm32       = '0;
    dec.rs1     = ins[19:15];
    dec.rs2     = ins[24:20];
    dec.rd      = ins[11:7];
    dec.opcode  = ins[6:0];
    dec.funct3  = ins[14:12];
    dec.funct7  = ins[31:25];
    dec.alu_sel = {ins[30], ins[14:12]};
    dec.pc      = bus.pc_i;
    case (ins[6:0])
      7'b0110011: dec.fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        dec.fmt = FMT_I;
        imm32   = {{20{ins[31]}}, ins[31:20]};
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        imm32   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        imm32   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        imm32   = {ins[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        imm32   = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      default: dec.fmt = FMT_BAD;
    endcase
    // Widen to XLEN: fill with the sign, then lay the 32-bit value on top.
    dec.imm       = {XLEN{imm32[31]}};
    dec.imm[31:0] = imm32;
`ifdef DECODE_ILLEGAL_CHECK_EN
    dec.illegal = (dec.fmt == FMT_BAD) ||
                  ((dec.fmt == FMT_R) && (ins[31:25] != 7'b0000000) &&
                   (ins[31:25] != 7'b0100000)) ||
                  (ins[1:0] != 2'b11);
    if (dec.illegal) dec.imm = '0;
`else
    dec.illegal = 1'b0;
`endif
  end

  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept, consume;

  assign accept  = bus.in_valid_i && in_ready_q;
  assign consume = main_valid_q && bus.out_ready_i;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (bus.flush_i) begin
      // Flush wins over both accept and consume; data regs keep stale contents.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume || !main_valid_q) begin
      if (skid_valid_q) begin
        // Skid is older than any new input, so it refills main first.
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = dec;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = dec;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    // Ready is derived from the next skid state so it can be a plain flop.
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = main_valid_q;
  assign bus.rs1_o       = main_q.rs1;
  assign bus.rs2_o       = main_q.rs2;
  assign bus.rd_o        = main_q.rd;
  assign bus.opcode_o    = main_q.opcode;
  assign bus.funct3_o    = main_q.funct3;
  assign bus.funct7_o    = main_q.funct7;
  assign bus.alu_sel_o   = main_q.alu_sel;
  assign bus.fmt_o       = main_q.fmt;
  assign bus.imm_o       = main_q.imm;
  assign bus.pc_o        = main_q.pc;
  assign bus.illegal_o   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: bench for decode_stage. A queue of accepted instructions
// stands in for the two-entry buffer; decoded fields are recomputed from the
// instruction word with field arithmetic.
module tb_decode_stage;
  localparam int XLEN = 32;
  localparam int PC_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();
  decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference decode ----------------
  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3, fmt;
    logic [3:0]  alu_sel;
    logic [63:0] imm;
    logic        illegal;
  } dec_t;

  function automatic logic [63:0] sext(input logic [63:0] val, input int bits);
    if (val[bits-1]) return val - (64'd1 << bits);
    return val;
  endfunction

  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    logic [63:0] v;
    v         = 64'd0;
    d.rs1     = w[19:15];
    d.rs2     = w[24:20];
    d.rd      = w[11:7];
    d.opcode  = w[6:0];
    d.funct3  = w[14:12];
    d.funct7  = w[31:25];
    d.alu_sel = {w[30], w[14:12]};
    case (w[6:0])
      7'h33:                      d.fmt = 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73: begin d.fmt = 3'd1; v = sext(64'(w[31:20]), 12); end
      7'h23: begin d.fmt = 3'd2; v = sext(64'({w[31:25], w[11:7]}), 12); end
      7'h63: begin d.fmt = 3'd3; v = sext(64'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13); end
      7'h37, 7'h17: begin d.fmt = 3'd4; v = sext(64'({w[31:12], 12'b0}), 32); end
      7'h6F: begin d.fmt = 3'd5; v = sext(64'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21); end
      default: d.fmt = 3'd7;
    endcase
`ifdef DECODE_ILLEGAL_CHECK_EN
    d.illegal = (d.fmt == 3'd7) || (w[1:0] != 2'b11) ||
                (d.fmt == 3'd0 && w[31:25] != 7'h00 && w[31:25] != 7'h20);
    if (d.illegal) v = 64'd0;
`else
    d.illegal = 1'b0;
`endif
    d.imm = (XLEN == 64) ? v : (v & 64'h0000_0000_FFFF_FFFF);
    return d;
  endfunction

  // ---------------- scoreboard model ----------------
  logic [31:0]     exp_q[$];
  logic [PC_W-1:0] pc_q[$];
  bit              m_in_ready = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      pc_q.delete();
      m_in_ready = 1'b1;
    end else begin
      bit acc;
      acc = bus.in_valid_i && m_in_ready;
      if (bus.flush_i) begin
        exp_q.delete();
        pc_q.delete();
      end else begin
        if (bus.out_ready_i && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          void'(pc_q.pop_front());
        end
        if (acc) begin
          exp_q.push_back(bus.instr_i);
          pc_q.push_back(bus.pc_i);
        end
      end
      m_in_ready = (exp_q.size() < 2);
    end
  end

  dec_t cd;
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 64'(bus.out_valid_o), 64'(exp_q.size() > 0));
      chk("in_ready", 64'(bus.in_ready_o), 64'(m_in_ready));
      if (exp_q.size() > 0) begin
        cd = ref_decode(exp_q[0]);
        chk("rs1", 64'(bus.rs1_o), 64'(cd.rs1));
        chk("rs2", 64'(bus.rs2_o), 64'(cd.rs2));
        chk("rd", 64'(bus.rd_o), 64'(cd.rd));
        chk("opcode", 64'(bus.opcode_o), 64'(cd.opcode));
        chk("funct3", 64'(bus.funct3_o), 64'(cd.funct3));
        chk("funct7", 64'(bus.funct7_o), 64'(cd.funct7));
        chk("alu_sel", 64'(bus.alu_sel_o), 64'(cd.alu_sel));
        chk("fmt", 64'(bus.fmt_o), 64'(cd.fmt));
        chk("imm", 64'(bus.imm_o), cd.imm);
        chk("pc", 64'(bus.pc_o), 64'(pc_q[0]));
        chk("illegal", 64'(bus.illegal_o), 64'(cd.illegal));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] w, input logic [PC_W-1:0] pc);
    bus.in_valid_i = 1'b1;
    bus.instr_i    = w;
    bus.pc_i       = pc;
    tick();
    bus.in_valid_i = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready_i = 1'b1;
    repeat (3) tick();
    bus.out_ready_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0: begin
        w[6:0] = 7'h33;
        case ($urandom_range(0, 2))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          default: ;
        endcase
      end
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h73;
      5: w[6:0] = 7'h23;
      6: w[6:0] = 7'h63;
      7: w[6:0] = 7'h37;
      8: w[6:0] = 7'h17;
      9: w[6:0] = 7'h6F;
      default: ;
    endcase
    return w;
  endfunction

  logic exp_ill_bad;
  logic exp_ill_r;

  initial begin
`ifdef DECODE_ILLEGAL_CHECK_EN
    exp_ill_bad = 1'b1;
    exp_ill_r   = 1'b1;
`else
    exp_ill_bad = 1'b0;
    exp_ill_r   = 1'b0;
`endif
    bus.flush_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.instr_i     = '0;
    bus.pc_i        = '0;
    bus.out_ready_i = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    chk("rst_imm", 64'(bus.imm_o), 64'd0);
    chk("rst_fmt", 64'(bus.fmt_o), 64'd0);
    chk("rst_illegal", 64'(bus.illegal_o), 64'd0);
    chk("rst_pc", 64'(bus.pc_o), 64'd0);
    tick();
    rst = 1'b0;

    // addi x1,x2,-1 accepted on the first edge after reset release
    push_one(32'hFFF10093, 32'h0000_1000);
    @(negedge clk);
    chk("addi_valid", 64'(bus.out_valid_o), 64'd1);
    chk("addi_rs1", 64'(bus.rs1_o), 64'd2);
    chk("addi_rd", 64'(bus.rd_o), 64'd1);
    chk("addi_fmt", 64'(bus.fmt_o), 64'd1);
    chk("addi_imm", 64'(bus.imm_o), 64'hFFFF_FFFF);
    drain();

    // beq x0,x0,-4 : B immediate fields give -4
    push_one(32'hFE000EE3, 32'h0000_1004);
    @(negedge clk);
    chk("b_fmt", 64'(bus.fmt_o), 64'd3);
    chk("b_imm", 64'(bus.imm_o), 64'hFFFF_FFFC);
    drain();

    // jal x1 with only bit 31 set: immediate is -2^20
    push_one(32'h800000EF, 32'h0000_1008);
    @(negedge clk);
    chk("j_fmt", 64'(bus.fmt_o), 64'd5);
    chk("j_imm", 64'(bus.imm_o), 64'hFFF0_0000);
    chk("j_rd", 64'(bus.rd_o), 64'd1);
    drain();

    // Unknown opcode, then R-type with funct7=0000001
    push_one(32'h0000007F, 32'h0000_2000);
    @(negedge clk);
    chk("bad_fmt", 64'(bus.fmt_o), 64'd7);
    chk("bad_illegal", 64'(bus.illegal_o), 64'(exp_ill_bad));
    chk("bad_imm", 64'(bus.imm_o), 64'd0);
    drain();
    push_one(32'h022080B3, 32'h0000_2004);
    @(negedge clk);
    chk("r7_fmt", 64'(bus.fmt_o), 64'd0);
    chk("r7_illegal", 64'(bus.illegal_o), 64'(exp_ill_r));
    drain();

    // Downstream stall with back-to-back inputs
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.instr_i = rand_instr();
      bus.pc_i    = $urandom;
      tick();
      if (i == 1) begin
        @(negedge clk);
        chk("stall_in_ready", 64'(bus.in_ready_o), 64'd0);
      end
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("stall_drained", 64'(bus.out_valid_o), 64'd0);

    // Flush with both entries full and a concurrent input
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    repeat (3) begin
      bus.instr_i = rand_instr();
      bus.pc_i    = $urandom;
      tick();
    end
    bus.flush_i = 1'b1;
    bus.instr_i = 32'h00A00513;
    tick();
    bus.flush_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready_o), 64'd1);
    bus.out_ready_i = 1'b1;
    repeat (3) tick();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      bus.in_valid_i  = ($urandom_range(0, 3) != 0);
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      bus.flush_i     = ($urandom_range(0, 40) == 0);
      bus.instr_i     = rand_instr();
      bus.pc_i        = $urandom;
      tick();
    end
    bus.in_valid_i = 1'b0;
    bus.flush_i    = 1'b0;
    drain();

    // Asynchronous reset while an entry is presented
    bus.out_ready_i = 1'b0;
    push_one(32'h12345037, 32'h0000_3000);
    @(negedge clk);
    chk("pre_rst_valid", 64'(bus.out_valid_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready_o), 64'd1);
    chk("arst_imm", 64'(bus.imm_o), 64'd0);
    chk("arst_rd", 64'(bus.rd_o), 64'd0);
    chk("arst_fmt", 64'(bus.fmt_o), 64'd0);
    chk("arst_pc", 64'(bus.pc_o), 64'd0);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
